// File: rtl/counter_pkg.sv
// Shared constants for the 0..19 counter: bin width, terminal count and
// the PAUSE/RUN state encoding used by counter_0to19_core.
package counter_pkg;

    localparam int CNT_W     = 5;
    localparam int MAX_COUNT = 19;

    localparam logic ST_PAUSE = 1'b0;
    localparam logic ST_RUN   = 1'b1;

endpackage

// File: rtl/counter_0to19_core_tick_gen.sv
// Prescaler for counter_0to19_core: counts 0..DIV-1 while enabled and
// flags the last cycle of each period. Holding en low freezes the count,
// so a resumed run finishes the partial period instead of restarting it.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Clear outranks the period end, so no tick escapes on a clear cycle.
    assign tick = en & ~clr & (cnt == LAST);

    // Prescaler: wrap at DIV-1, hold when disabled, zero on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_0to19_core.sv
// 0..MAX_COUNT modulo counter feeding binary_bcd. A debounced start/stop
// button toggles between PAUSE and RUN; the prescaler in tick_gen sets the
// count rate; clr zeroes the count and prescaler without touching state.
// Build option COUNTER_DOWN_EN adds a dir input (1 = count down).
//
//   state    | meaning
//   ---------+------------------------------------------
//   ST_PAUSE | prescaler frozen, bin held
//   ST_RUN   | prescaler running, bin steps on each tick
module counter_0to19_core #(
    parameter int DIV       = 50_000_000,
    parameter int MAX_COUNT = counter_pkg::MAX_COUNT,
    parameter int CNT_W     = counter_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_ss,
    input  logic             clr,
`ifdef COUNTER_DOWN_EN
    input  logic             dir,
`endif
    output logic [CNT_W-1:0] bin,
    output logic             running,
    output logic             tick,
    output logic             wrap
);

    import counter_pkg::*;

    localparam logic [CNT_W-1:0] BIN_MAX = CNT_W'(MAX_COUNT);

    logic             sync1;
    logic             sync2;
    logic             hist;
    logic             btn_edge;
    logic             state;
    logic             tick_int;
    logic [CNT_W-1:0] bin_next;
    logic             wrap_int;

    // Two-flop synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= btn_ss;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign btn_edge = sync2 & ~hist;

    // PAUSE/RUN toggle; a held button yields one edge and so one toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PAUSE;
        end else if (btn_edge) begin
            state <= ~state;
        end
    end

    assign running = (state == ST_RUN);

    // Prescaler runs off the current state, so a tick coinciding with a
    // pause toggle is still applied before the state flips.
    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (running),
        .clr   (clr),
        .tick  (tick_int)
    );

    // Next count and wrap flag, both judged on the pre-update value.
    always_comb begin
        bin_next = (bin == BIN_MAX) ? '0 : bin + 1'b1;
        wrap_int = tick_int & (bin == BIN_MAX);
`ifdef COUNTER_DOWN_EN
        if (dir) begin
            bin_next = (bin == '0) ? BIN_MAX : bin - 1'b1;
            wrap_int = tick_int & (bin == '0);
        end
`endif
    end

    // Count register: clear wins over tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin <= '0;
        end else if (clr) begin
            bin <= '0;
        end else if (tick_int) begin
            bin <= bin_next;
        end
    end

    assign tick = tick_int;
    assign wrap = wrap_int;

endmodule

// File: tb/tb_counter_0to19_core.sv
// Bench for counter_0to19_core with DIV = 4. Stimulus pushes the expected
// (cycle, pre-update bin, wrap) of every tick into a queue; a monitor pops
// and compares each time the DUT asserts tick.
module tb_counter_0to19_core;

    localparam int DIV = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       btn_ss = 1'b0;
    logic       clr    = 1'b0;
`ifdef COUNTER_DOWN_EN
    logic       dir    = 1'b0;
`endif
    logic [4:0] bin;
    logic       running;
    logic       tick;
    logic       wrap;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int p, r;
`ifdef COUNTER_DOWN_EN
    int s;
`endif

    typedef struct {
        int c;
        int b;
        bit w;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    counter_0to19_core #(
        .DIV (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_ss  (btn_ss),
        .clr     (clr),
`ifdef COUNTER_DOWN_EN
        .dir     (dir),
`endif
        .bin     (bin),
        .running (running),
        .tick    (tick),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int b, input bit w);
        exp_t x;
        x.c = c;
        x.b = b;
        x.w = w;
        sbq.push_back(x);
    endtask

    // Resume 1 time unit after the posedge that brings cyc to c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Resume on the negedge inside cycle c.
    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Monitor: every tick must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tick === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick: tick at cycle %0d bin %0d, none expected", cyc, bin);
                end else begin
                    e = sbq.pop_front();
                    if (cyc != e.c || bin !== 5'(e.b) || wrap !== e.w) begin
                        errors++;
                        $display("FAIL tick_compare: got cycle %0d bin %0d wrap %0b expected cycle %0d bin %0d wrap %0b",
                                 cyc, bin, wrap, e.c, e.b, e.w);
                    end
                end
            end
            if (rst_n && wrap === 1'b1 && tick !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL wrap_without_tick: wrap 1 tick %0b at cycle %0d", tick, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset: nothing moves without the button.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_after_reset", {bin, running, tick, wrap}, 0);
        end

        // Start: button held 10 cycles, sampled at edge p+1, RUN at edge p+3.
        @(posedge clk);
        #1;
        p = cyc;
        btn_ss = 1'b1;
        for (int k = 0; k < 27; k++)
            push(p + 6 + 4 * k, k % 20, (k % 20) == 19);
        wait_neg(p + 2);
        chk("run_latency_early", running, 0);
        wait_neg(p + 3);
        chk("run_latency", running, 1);
        goto(p + 10);
        btn_ss = 1'b0;
        wait_neg(p + 20);
        chk("single_toggle", running, 1);

        // Pause right after bin reaches 7, prescaler frozen at 2.
        goto(p + 110);
        btn_ss = 1'b1;
        wait_neg(p + 112);
        chk("pause_pending", running, 1);
        wait_neg(p + 113);
        chk("paused", running, 0);
        chk("pause_bin", bin, 7);
        goto(p + 115);
        btn_ss = 1'b0;
        wait_neg(p + 132);
        chk("pause_hold_bin", bin, 7);

        // Resume: only the remaining part of the period is waited out.
        r = p + 133;
        goto(r);
        btn_ss = 1'b1;
        for (int j = 0; j < 5; j++)
            push(r + 4 + 4 * j, 7 + j, 1'b0);
        wait_neg(r + 3);
        chk("resumed", running, 1);
        goto(r + 6);
        btn_ss = 1'b0;

        // Clear on the cycle the bin=12 tick is due.
        goto(r + 24);
        clr = 1'b1;
        wait_neg(r + 24);
        chk("clr_tick_suppressed", tick, 0);
        chk("clr_wrap_suppressed", wrap, 0);
        goto(r + 25);
        clr = 1'b0;
        chk("clr_bin", bin, 0);
        chk("clr_keeps_run", running, 1);
        for (int m = 0; m < 15; m++)
            push(r + 28 + 4 * m, m, 1'b0);

        // Asynchronous reset mid-count.
        goto(r + 87);
        chk("pre_reset_bin", bin, 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bin, running, tick, wrap}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("idle_after_rerelease", {bin, running, tick, wrap}, 0);
        end

`ifdef COUNTER_DOWN_EN
        // Down count from 0 wraps to MAX_COUNT with wrap asserted.
        @(posedge clk);
        #1;
        s = cyc;
        dir = 1'b1;
        btn_ss = 1'b1;
        push(s + 6, 0, 1'b1);
        push(s + 10, 19, 1'b0);
        push(s + 14, 18, 1'b0);
        goto(s + 10);
        btn_ss = 1'b0;
        wait_neg(s + 11);
        chk("down_wrap_bin", bin, 19);
        wait_neg(s + 15);
`endif

        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
